// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, sign fix-up on completion.
module muldiv_unit #(
  parameter int unsigned DATA_BUS_WIDTH   = 32,
  parameter int unsigned MDU_OP_BUS_WIDTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [MDU_OP_BUS_WIDTH-1:0] i_op,
  input  logic [DATA_BUS_WIDTH-1:0]   i_a,
  input  logic [DATA_BUS_WIDTH-1:0]   i_b,
  input  logic                        i_flush,
  input  logic                        i_wr_hi,
  input  logic                        i_wr_lo,
  input  logic [DATA_BUS_WIDTH-1:0]   i_wr_data,
  output logic [DATA_BUS_WIDTH-1:0]   o_hi,
  output logic [DATA_BUS_WIDTH-1:0]   o_lo,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int unsigned W     = DATA_BUS_WIDTH;
  localparam int unsigned W2    = 2 * DATA_BUS_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_BUS_WIDTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     p_hi_q, p_hi_d;
  logic [W-1:0]     p_lo_q, p_lo_d;
  logic [W-1:0]     a_raw_q, a_raw_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand decode: bit 1 selects divide, bit 0 selects unsigned
  logic         signed_op_c;
  logic [W-1:0] mag_a_c, mag_b_c;
  assign signed_op_c = ~i_op[0];
  assign mag_a_c = (signed_op_c && i_a[W-1]) ? (~i_a + W'(1)) : i_a;
  assign mag_b_c = (signed_op_c && i_b[W-1]) ? (~i_b + W'(1)) : i_b;

  // Iteration datapath shared between multiply and divide
  logic [W:0]    mul_sum_c, div_trial_c;
  logic [W2-1:0] prod_c, prod_fix_c;
  logic [W-1:0]  quo_fix_c, rem_fix_c;
  assign mul_sum_c   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_trial_c = {p_hi_q, p_lo_q[W-1]} - {1'b0, opb_q};
  assign prod_c      = {p_hi_q, p_lo_q};
  assign prod_fix_c  = neg_lo_q ? (~prod_c + W2'(1)) : prod_c;
  assign quo_fix_c   = neg_lo_q ? (~p_lo_q + W'(1)) : p_lo_q;
  assign rem_fix_c   = neg_hi_q ? (~p_hi_q + W'(1)) : p_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opb_d    = opb_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    a_raw_d  = a_raw_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (i_wr_hi) hi_d = i_wr_data;
        if (i_wr_lo) lo_d = i_wr_data;
        if (i_start && !i_flush) begin
          is_div_d = i_op[1];
          p_hi_d   = '0;
          p_lo_d   = i_op[1] ? mag_a_c : mag_b_c;
          opb_d    = i_op[1] ? mag_b_c : mag_a_c;
          a_raw_d  = i_a;
          neg_lo_d = signed_op_c && (i_a[W-1] ^ i_b[W-1]);
          neg_hi_d = signed_op_c && i_a[W-1];
          div0_d   = (i_b == '0);
          cnt_d    = CNT_W'(W - 1);
          state_d  = S_RUN;
          busy_d   = 1'b1;
        end
      end

      S_RUN: begin
        if (i_flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            if (!div_trial_c[W]) begin
              p_hi_d = div_trial_c[W-1:0];
              p_lo_d = {p_lo_q[W-2:0], 1'b1};
            end else begin
              p_hi_d = {p_hi_q[W-2:0], p_lo_q[W-1]};
              p_lo_d = {p_lo_q[W-2:0], 1'b0};
            end
          end else begin
            p_hi_d = mul_sum_c[W:1];
            p_lo_d = {mul_sum_c[0], p_lo_q[W-1:1]};
          end
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!i_flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix_c[W2-1:W];
            lo_d = prod_fix_c[W-1:0];
          end else if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix_c;
            lo_d = quo_fix_c;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opb_q    <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      a_raw_q  <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opb_q    <= opb_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      a_raw_q  <= a_raw_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_BUS_WIDTH, default 32, operand/result width W; SHALL be even and >= 4.
REQ-002 Parameter MDU_OP_BUS_WIDTH, default 2, operation code width; codes SHALL be 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_start  input  1  request a new operation, sampled only in IDLE.
REQ-006 i_op  input  MDU_OP_BUS_WIDTH  operation code, sampled with i_start.
REQ-007 i_a / i_b  input  W each  multiplicand/dividend and multiplier/divisor, sampled with i_start.
REQ-008 i_flush  input  1  abort the in-flight operation (pipeline flush).
REQ-009 i_wr_hi / i_wr_lo  input  1 each  direct write of HI/LO (MTHI/MTLO).
REQ-010 i_wr_data  input  W  data for i_wr_hi/i_wr_lo.
REQ-011 o_hi / o_lo  output  W each  architectural HI/LO registers.
REQ-012 o_busy  output  1  high in RUN and DONE; used by the hazard unit to stall MFHI/MFLO/new MDU ops.
REQ-013 o_done  output  1  one-cycle pulse: HI/LO were just updated by a completed operation.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE & i_start & !i_flush: latch op, |i_a|, |i_b| (magnitudes for MULT/DIV, raw for MULTU/DIVU), result sign flags; load iteration counter with W-1; go RUN.
REQ-016 RUN: one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle; after counter reaches 0 (W iterations total) go DONE.
REQ-017 DONE: apply sign correction, write HI/LO, pulse o_done, go IDLE -- on one edge.
REQ-018 Latency: start accepted at edge E0 -> HI/LO written and o_done high after edge E0+W+1 (E33 for W=32); next start accepted in that same o_done cycle.
REQ-019 Multiply: {HI,LO} SHALL equal the full 2W-bit product, signed (MULT) or unsigned (MULTU).
REQ-020 Divide: LO = quotient truncated toward zero, HI = remainder with sign of dividend (DIV); unsigned for DIVU.
REQ-021 Divide by zero: same latency; LO = all ones, HI = i_a as sampled.
REQ-022 DIV of most-negative by -1: LO = most-negative value, HI = 0.
REQ-023 i_start while o_busy SHALL be ignored; no queuing.
REQ-024 i_flush in RUN or DONE: return to IDLE next edge, HI/LO unchanged, no o_done; i_flush with i_start in IDLE: start ignored.
REQ-025 i_wr_hi/i_wr_lo in IDLE: write i_wr_data next edge; while o_busy: ignored. Both asserted: both written.
REQ-026 i_wr_* and operation completion SHALL never coincide (DONE exits to IDLE before writes are honoured).

Reset
REQ-027 i_reset low SHALL immediately force IDLE, o_hi = 0, o_lo = 0, o_busy = 0, o_done = 0, counter = 0, regardless of clock.
REQ-028 Reset asserted mid-operation SHALL discard the operation; first start after deassertion behaves per REQ-015.

Verification
REQ-029 MULT i_a=-3 (0xFFFFFFFD), i_b=7 -> o_done after E33; o_hi=0xFFFFFFFF, o_lo=0xFFFFFFEB; o_busy high exactly 33 cycles.
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_hi=0xFFFFFFFE, o_lo=0x00000001.
REQ-031 DIV -7 / 2 -> o_lo=0xFFFFFFFD (-3), o_hi=0xFFFFFFFF (-1); DIVU 7/0 -> o_lo=0xFFFFFFFF, o_hi=0x00000007.
REQ-032 Start DIVU 100/7, assert i_flush at E10 -> IDLE next edge, no o_done, HI/LO keep prior values; i_start during RUN ignored (busy count unchanged).
REQ-033 i_wr_hi=1, i_wr_data=0x12345678 in IDLE -> o_hi=0x12345678 next edge; same write during RUN -> o_hi unchanged.
REQ-034 Pull i_reset low at E20 of a MULT, between clock edges -> outputs zero immediately; release, MULTU 5x6 -> o_lo=30, o_hi=0 after E33.
